wave_synth: RTL and testbench
=============================

WAVE_SYNTH -- requirements
Module: wave_synth

Interface
REQ-001 Parameter DATA_W, default 8, waveform sample width, legal range 8..16.
REQ-002 Parameter PHASE_W, default 24, phase-accumulator width, legal range 16..32.
REQ-003 Parameter MUL_W, default 3, amplitude-multiplier width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  generator run enable.
REQ-007 cfg_load  input  1  single-cycle strobe capturing wave_cs/mul/ftw into shadow registers.
REQ-008 wave_cs  input  3  waveform code: 0 sine, 1 triangle, 2 square, 3 noise, 4 sawtooth, 5..7 reserved.
REQ-009 mul  input  MUL_W  amplitude code; gain = mul+1.
REQ-010 ftw  input  PHASE_W  frequency tuning word added to phase each enabled cycle.
REQ-011 cfg_pend  output  1  shadow config captured but not yet active.
REQ-012 wrap  output  1  one-cycle pulse on accumulator carry-out.
REQ-013 q_valid  output  1  q holds an enabled-cycle sample.
REQ-014 q  output  DATA_W+MUL_W  scaled sample, unsigned.

Function
REQ-015 Phase register SHALL add active ftw modulo 2^PHASE_W each cycle en=1, hold when en=0; wrap=1 in the cycle the addition carries out.
REQ-016 Index p = top DATA_W bits of phase; saw = p; square = all-ones if p MSB=0 else 0; triangle = {p[DATA_W-2:0],0} when p MSB=0, else its bitwise inverse.
REQ-017 Sine SHALL come from a 256-entry 8-bit unsigned table (midscale 128) addressed by top 8 phase bits, left-aligned and zero-padded to DATA_W.
REQ-018 Noise SHALL be the top DATA_W bits of a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing each en=1 cycle; for DATA_W=16 all bits.
REQ-019 Reserved wave codes SHALL yield sample 0.
REQ-020 Pipeline: stage 1 phase/LFSR, stage 2 registered selected sample, stage 3 registered q = sample*(mul_active+1), full width, no truncation; q lags phase by 2 cycles.
REQ-021 q_valid SHALL equal en delayed 2 cycles; q SHALL be 0 whenever q_valid=0.
REQ-022 cfg_load SHALL set cfg_pend and overwrite shadows; repeated loads before apply keep only the last.
REQ-023 With en=1, active config SHALL update from shadow in the cycle wrap=1 and cfg_pend=1, clearing cfg_pend; waveform changes only on period boundaries.
REQ-024 cfg_load coincident with wrap SHALL be captured and applied at the following wrap, not this one.
REQ-025 With en=0 and cfg_pend=1, active config SHALL update on the next cycle.
REQ-026 mul_active SHALL travel with the sample so gain changes align with waveform changes at q.

Reset
REQ-027 reset_n low SHALL clear phase, active/shadow config, pipeline, q, q_valid, wrap, cfg_pend to 0 and load LFSR with 16'hACE1, asynchronously; release synchronous to clk.
REQ-028 Reset mid-period SHALL discard pending config.

Configuration
REQ-029 Macro WAVE_SYNTH_PHASE_OFS_EN defined: extra input phase_ofs [PHASE_W-1:0] added (modulo) to phase before index extraction only, never accumulated, not shadowed.
REQ-030 Macro undefined: port absent, offset 0, behaviour identical to REQ-016..017.

Structure
REQ-031 Package wave_synth_pkg SHALL hold waveform code constants, LFSR seed and tap constants, sine table depth/width.
REQ-032 Sub-module wave_sin_lut SHALL hold the sine table with one registered read port (stage 2).

Verification (DATA_W=8, PHASE_W=16, MUL_W=3)
REQ-033 Reset: assert reset_n=0 mid-run -> q=0, q_valid=0, cfg_pend=0 immediately; first q after release with en=1 appears 2 cycles later.
REQ-034 Saw, ftw=16'h0100, mul=0 -> q = 0,1,2,...,255,0 one step per cycle; wrap every 256 cycles.
REQ-035 Square, ftw=16'h0100, mul=7 -> q = 2040 for 128 cycles then 0 for 128 cycles.
REQ-036 Saw running, cfg_load tri at phase 16'h4000 -> cfg_pend high, saw continues to wrap, tri starts at index 0 next period; load on wrap cycle deferred one full period.
REQ-037 en dropped 10 cycles mid-period -> phase holds, q=0 2 cycles later, resumes from held phase; cfg_load during en=0 applies next cycle.
REQ-038 Noise, mul=0 -> q sequence equals top 8 bits of reference LFSR from 16'hACE1.

Source files
------------

// File: rtl/wave_synth_pkg.sv
// wave_synth_pkg: shared waveform codes, LFSR constants and sine table geometry.
package wave_synth_pkg;
  typedef enum logic [2:0] {
    WAVE_SIN   = 3'd0,
    WAVE_TRI   = 3'd1,
    WAVE_SQR   = 3'd2,
    WAVE_NOISE = 3'd3,
    WAVE_SAW   = 3'd4
  } wave_e;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam int SIN_DEPTH = 256;
  localparam int SIN_W = 8;
  localparam int SIN_AW = $clog2(SIN_DEPTH);
  localparam logic [SIN_W-1:0] SIN_MID = 8'd128;
endpackage

// File: rtl/wave_sin_lut.sv
// wave_sin_lut: 256x8 unsigned sine table (midscale 128) with one registered read port.
module wave_sin_lut
  import wave_synth_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [SIN_AW-1:0] addr,
  output logic [SIN_W-1:0]  data
);
  // Quarter wave round(127*sin(k*pi/128)), k = 0..64; the rest follows by symmetry.
  localparam logic [SIN_W-1:0] QTAB [SIN_DEPTH/4+1] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,  8'd25,  8'd28,
    8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,  8'd49,  8'd51,  8'd54,  8'd57,
    8'd60,  8'd63,  8'd65,  8'd68,  8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,
    8'd85,  8'd88,  8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
    8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116, 8'd117, 8'd118,
    8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125, 8'd125, 8'd126, 8'd126,
    8'd126, 8'd127, 8'd127, 8'd127, 8'd127
  };
  logic [SIN_AW-2:0] m;
  assign m = addr[SIN_AW-2] ? -addr[SIN_AW-2:0] : addr[SIN_AW-2:0];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) data <= '0;
    else data <= addr[SIN_AW-1] ? SIN_MID - QTAB[m] : SIN_MID + QTAB[m];
endmodule

// File: rtl/wave_synth.sv
// wave_synth: DDS waveform generator whose shadowed config takes effect on a period wrap.
// Define WAVE_SYNTH_PHASE_OFS_EN to add a phase_ofs input that offsets the table index only.
module wave_synth
  import wave_synth_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 24,
  parameter int MUL_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [2:0]              wave_cs,
  input  logic [MUL_W-1:0]        mul,
  input  logic [PHASE_W-1:0]      ftw,
`ifdef WAVE_SYNTH_PHASE_OFS_EN
  input  logic [PHASE_W-1:0]      phase_ofs,
`endif
  output logic                    cfg_pend,
  output logic                    wrap,
  output logic                    q_valid,
  output logic [DATA_W+MUL_W-1:0] q
);
  localparam int QW = DATA_W + MUL_W;
  logic [PHASE_W-1:0] phase, phase_nx, idx_phase, ftw_act, ftw_sh;
  logic [2:0]         wave_act, wave_sh;
  logic [MUL_W-1:0]   mul_act, mul_sh, s_mul;
  logic [LFSR_W-1:0]  lfsr;
  logic [DATA_W-1:0]  p, tri_w, sel, s_other, sample;
  logic [SIN_W-1:0]   sin_q;
  logic               carry, apply, s_is_sin, s_valid;
  assign {carry, phase_nx} = {1'b0, phase} + {1'b0, ftw_act};
  assign wrap  = en & carry;
  // Running: swap config only at a period boundary; idle: swap at once.
  assign apply = cfg_pend & (wrap | ~en);
`ifdef WAVE_SYNTH_PHASE_OFS_EN
  assign idx_phase = phase + phase_ofs;
`else
  assign idx_phase = phase;
`endif
  assign p     = DATA_W'(idx_phase >> (PHASE_W - DATA_W));
  assign tri_w = {p[DATA_W-2:0], 1'b0} ^ {DATA_W{p[DATA_W-1]}};
  always_comb
    sel = wave_act == WAVE_TRI   ? tri_w :
          wave_act == WAVE_SQR   ? {DATA_W{~p[DATA_W-1]}} :
          wave_act == WAVE_NOISE ? lfsr[LFSR_W-1 -: DATA_W] :
          wave_act == WAVE_SAW   ? p : '0;
  wave_sin_lut u_sin (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (p[DATA_W-1 -: SIN_AW]),
    .data    (sin_q)
  );
  // The sine read is registered inside the LUT, so it joins the mux after stage 2.
  assign sample = s_is_sin ? DATA_W'(sin_q) << (DATA_W - SIN_W) : s_other;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {wave_sh, mul_sh, ftw_sh}    <= '0;
      {wave_act, mul_act, ftw_act} <= '0;
      cfg_pend <= 1'b0;
      phase    <= '0;
      lfsr     <= LFSR_SEED;
      s_other  <= '0;
      s_is_sin <= 1'b0;
      s_mul    <= '0;
      s_valid  <= 1'b0;
      q_valid  <= 1'b0;
      q        <= '0;
    end else begin
      if (cfg_load) {wave_sh, mul_sh, ftw_sh} <= {wave_cs, mul, ftw};
      if (apply) {wave_act, mul_act, ftw_act} <= {wave_sh, mul_sh, ftw_sh};
      cfg_pend <= cfg_load | (cfg_pend & ~apply);
      if (en) begin
        phase <= phase_nx;
        lfsr  <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
      end
      s_other  <= sel;
      s_is_sin <= wave_act == WAVE_SIN;
      s_mul    <= mul_act;
      s_valid  <= en;
      q_valid  <= s_valid;
      q        <= s_valid ? QW'(sample) * (QW'(s_mul) + QW'(1)) : '0;
    end
endmodule

// File: tb/tb_wave_synth.sv
// tb_wave_synth: vector table plus directed sequences, with a queue scoreboard on q.
module tb_wave_synth;
  import wave_synth_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic [2:0]  wave_cs = '0;
  logic [2:0]  mul = '0;
  logic [15:0] ftw = '0;
  logic [15:0] phase_ofs = '0;
  logic        cfg_pend, wrap, q_valid;
  logic [10:0] q;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [10:0] v; string nm;} exp_t;
  exp_t sb[$];
  typedef struct {logic [2:0] w; int m; int f; int e0; int e1;} vec_t;
  vec_t vt[16];
  always #5 clk = ~clk;
  wave_synth #(.DATA_W(8), .PHASE_W(16), .MUL_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .cfg_load (cfg_load),
    .wave_cs  (wave_cs),
    .mul      (mul),
    .ftw      (ftw),
`ifdef WAVE_SYNTH_PHASE_OFS_EN
    .phase_ofs(phase_ofs),
`endif
    .cfg_pend (cfg_pend),
    .wrap     (wrap),
    .q_valid  (q_valid),
    .q        (q)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push(input int v, input string nm);
    exp_t e;
    e.v = 11'(v);
    e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic load(input logic [2:0] w, input int m, input int f);
    wave_cs = w;
    mul = 3'(m);
    ftw = 16'(f);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask
  task automatic load_apply(input logic [2:0] w, input int m, input int f);
    en = 1'b0;
    load(w, m, f);
    chk("pend_set", cfg_pend, 1);
    step();
    chk("pend_idle_apply", cfg_pend, 0);
  endtask
  task automatic do_reset();
    en = 1'b0;
    cfg_load = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    sb.delete();
    reset_n = 1'b1;
  endtask
  task automatic drain();
    en = 1'b0;
    for (int i = 0; i < 6 && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 0);
  endtask
  function automatic int tri_f(input int p);
    return p < 128 ? 2 * p : 511 - 2 * p;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (q_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: q=%0d arrived with nothing expected", q);
      end else begin
        e = sb.pop_front();
        if (q !== e.v) begin
          errors++;
          $display("FAIL %s: q=%0d expected %0d", e.nm, q, e.v);
        end
      end
    end else if (q !== '0) begin
      checks++;
      errors++;
      $display("FAIL q_idle: q=%0d while q_valid=0, expected 0", q);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [15:0] r;
    vt = '{
      '{WAVE_SAW, 0, 'h0100,   0,    1},
      '{WAVE_SAW, 7, 'hFF00,   0, 2040},
      '{WAVE_SQR, 0, 'h7F00, 255,  255},
      '{WAVE_SQR, 1, 'h8000, 510,    0},
      '{WAVE_TRI, 0, 'h4000,   0,  128},
      '{WAVE_TRI, 2, 'h7F00,   0,  762},
      '{WAVE_TRI, 0, 'h8000,   0,  255},
      '{WAVE_TRI, 0, 'hFF00,   0,    1},
      '{WAVE_SIN, 0, 'h4000, 128,  255},
      '{WAVE_SIN, 3, 'hC000, 512,    4},
      '{WAVE_SIN, 0, 'h8000, 128,  128},
      '{WAVE_SIN, 0, 'h2000, 128,  218},
      '{WAVE_SIN, 0, 'h0100, 128,  131},
      '{WAVE_SIN, 0, 'hFF00, 128,  125},
      '{3'd5,     7, 'h4000,   0,    0},
      '{3'd7,     0, 'h4000,   0,    0}
    };
    step();
    step();
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_cfg_pend", cfg_pend, 0);
    chk("rst_wrap", wrap, 0);
    reset_n = 1'b1;
    // Each vector: sample at phase 0, then at phase = ftw.
    foreach (vt[i]) begin
      do_reset();
      load_apply(vt[i].w, vt[i].m, vt[i].f);
      en = 1'b1;
      push(vt[i].e0, $sformatf("vec%0d_ph0", i));
      step();
      push(vt[i].e1, $sformatf("vec%0d_ph1", i));
      step();
      drain();
    end
    // Sawtooth sweep with wrap pulses.
    do_reset();
    load_apply(WAVE_SAW, 0, 'h0100);
    en = 1'b1;
    for (int k = 0; k < 512; k++) begin
      push(k % 256, "saw_sweep");
      #2;
      chk("saw_wrap", wrap, (k % 256) == 255);
      step();
    end
    drain();
    // Square at full gain.
    do_reset();
    load_apply(WAVE_SQR, 7, 'h0100);
    en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      push(k < 128 ? 2040 : 0, "square_x8");
      step();
    end
    drain();
    // Mid-period double load (last wins) and a load on the wrap cycle.
    do_reset();
    load_apply(WAVE_SAW, 0, 'h0100);
    en = 1'b1;
    for (int k = 0; k < 900; k++) begin
      cfg_load = (k == 64 || k == 65 || k == 511);
      wave_cs = k == 64 ? WAVE_SIN : k == 65 ? WAVE_TRI : WAVE_SAW;
      mul = k == 511 ? 3'd1 : 3'd0;
      if (k == 66 || k == 255 || k == 512 || k == 767) chk("pend_hi", cfg_pend, 1);
      if (k == 256 || k == 768) chk("pend_lo", cfg_pend, 0);
      push(k < 256 ? k : k < 768 ? tri_f(k % 256) : 2 * (k % 256), "cfg_switch");
      step();
    end
    cfg_load = 1'b0;
    drain();
    // Enable dropped for 10 cycles with a load applied while idle.
    do_reset();
    load_apply(WAVE_SAW, 0, 'h0100);
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push(k, "pre_pause");
      step();
    end
    en = 1'b0;
    #2;
    chk("pause_qv0", q_valid, 1);
    step();
    chk("pause_qv1", q_valid, 1);
    step();
    chk("pause_qv2", q_valid, 0);
    step();
    load(WAVE_SAW, 3, 'h0100);
    chk("pause_pend_set", cfg_pend, 1);
    step();
    chk("pause_pend_clr", cfg_pend, 0);
    repeat (5) step();
    en = 1'b1;
    for (int k = 100; k < 200; k++) begin
      push(4 * k, "resume");
      step();
    end
    drain();
    // Noise against a reference LFSR from the seed.
    do_reset();
    load_apply(WAVE_NOISE, 0, 'h0100);
    r = 16'hACE1;
    en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      push(int'(r[15:8]), "noise");
      r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
      step();
    end
    drain();
    // Asynchronous reset mid-period with a load pending.
    do_reset();
    load_apply(WAVE_SAW, 0, 'h0100);
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push(k, "pre_reset");
      step();
    end
    load(WAVE_TRI, 0, 'h0100);
    chk("mid_pend", cfg_pend, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_q", q, 0);
    chk("async_q_valid", q_valid, 0);
    chk("async_pend", cfg_pend, 0);
    sb.delete();
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(128, "post_reset_sine");
      #2;
      if (i < 3) chk("post_reset_latency", q_valid, i == 2);
      chk("post_reset_pend", cfg_pend, 0);
      step();
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
